// File: rtl/dot_matrix_pkg.sv
// Shared types and constants for the 16x16 dot-matrix scan capture block.
package dot_matrix_pkg;

  localparam int COLS            = 16;
  localparam int ROWS            = 16;
  localparam int CW              = 4;
  localparam int TIMEOUT_DEFAULT = 1024;

  typedef logic [ROWS-1:0] row_t;
  typedef row_t [COLS-1:0] frame_t;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } cap_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/scan_frame_buffer.sv
// Shadow/committed frame double buffer with registered readback.
// SCAN_CAPTURE_DIFF_EN adds a shadow-vs-committed compare output.
module scan_frame_buffer
  import dot_matrix_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_col,
  input  row_t          wr_rows,
  input  logic          commit,
  input  logic [CW-1:0] rd_col,
`ifdef SCAN_CAPTURE_DIFF_EN
  output logic          frame_diff,
`endif
  output row_t          rd_rows
);

  frame_t shadow_q, shadow_d;
  frame_t committed_q, committed_d;
  row_t   rd_rows_q, rd_rows_d;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      shadow_d[wr_col] = wr_rows;
    end
    committed_d = commit ? shadow_q : committed_q;
    // Read sees the committed image as it was before this edge's commit.
    rd_rows_d = committed_q[rd_col];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q    <= '0;
      committed_q <= '0;
      rd_rows_q   <= '0;
    end else begin
      shadow_q    <= shadow_d;
      committed_q <= committed_d;
      rd_rows_q   <= rd_rows_d;
    end
  end

  assign rd_rows = rd_rows_q;

`ifdef SCAN_CAPTURE_DIFF_EN
  logic [COLS-1:0] col_diff;
  for (genvar gi = 0; gi < COLS; gi++) begin : g_diff
    assign col_diff[gi] = |(shadow_q[gi] ^ committed_q[gi]);
  end
  assign frame_diff = |col_diff;
`endif

endmodule

// File: rtl/dot_matrix_scan_capture.sv
// Rebuilds 16x16 dot-matrix frames from the column scan stream; flags errors and stalls.
// Optional macro SCAN_CAPTURE_DIFF_EN enables frame_changed (frame compare on commit).
module dot_matrix_scan_capture
  import dot_matrix_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scan_valid,
  input  logic [CW-1:0]   scan_cols,
  input  logic [ROWS-1:0] scan_rows,
  input  logic [CW-1:0]   rd_col,
  output logic [ROWS-1:0] rd_rows,
  output logic            frame_done,
  output logic            frame_changed,
  output logic            seq_err,
  output logic            stall,
  output logic            locked,
  output logic [7:0]      frame_count,
  output logic [7:0]      err_count
);

  localparam int            IW        = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] TIMEOUT_V = IW'(TIMEOUT);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_ONE   = CW'(1);

  cap_state_t    state_q, state_d;
  logic [CW-1:0] expect_q, expect_d;
  logic [IW-1:0] idle_q, idle_d, idle_inc;
  logic          frame_done_q, frame_done_d;
  logic          seq_err_q, seq_err_d;
  logic          stall_q, stall_d;
  logic          locked_q, locked_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          wr_en;
  logic          commit;

  always_comb begin
    state_d       = state_q;
    expect_d      = expect_q;
    idle_d        = '0;
    idle_inc      = idle_q + 1'b1;
    frame_done_d  = 1'b0;
    seq_err_d     = 1'b0;
    stall_d       = 1'b0;
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
    wr_en         = 1'b0;
    commit        = 1'b0;

    case (state_q)
      SYNC: begin
        if (scan_valid && scan_cols == '0) begin
          wr_en    = 1'b1;
          expect_d = COL_ONE;
          state_d  = CAPTURE;
        end
      end

      CAPTURE: begin
        if (scan_valid) begin
          if (scan_cols == expect_q) begin
            wr_en = 1'b1;
            if (expect_q == LAST_COL) begin
              state_d  = COMMIT;
              expect_d = '0;
            end else begin
              expect_d = expect_q + 1'b1;
            end
          end else if (scan_cols == expect_q - 1'b1) begin
            // Repeated strobe of the column just taken: latest data wins.
            wr_en = 1'b1;
          end else begin
            seq_err_d   = 1'b1;
            err_count_d = sat_inc8(err_count_q);
            if (scan_cols == '0) begin
              wr_en    = 1'b1;
              expect_d = COL_ONE;
            end else begin
              state_d  = SYNC;
              expect_d = '0;
            end
          end
        end else if (idle_inc == TIMEOUT_V) begin
          stall_d     = 1'b1;
          err_count_d = sat_inc8(err_count_q);
          state_d     = SYNC;
          expect_d    = '0;
        end else begin
          idle_d = idle_inc;
        end
      end

      COMMIT: begin
        commit        = 1'b1;
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
        // A column 0 arriving now is the start of the next frame.
        if (scan_valid && scan_cols == '0) begin
          wr_en    = 1'b1;
          expect_d = COL_ONE;
          state_d  = CAPTURE;
        end else begin
          state_d  = SYNC;
          expect_d = '0;
        end
      end

      default: begin
        state_d  = SYNC;
        expect_d = '0;
      end
    endcase

    locked_d = (state_d == CAPTURE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SYNC;
      expect_q      <= '0;
      idle_q        <= '0;
      frame_done_q  <= 1'b0;
      seq_err_q     <= 1'b0;
      stall_q       <= 1'b0;
      locked_q      <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      expect_q      <= expect_d;
      idle_q        <= idle_d;
      frame_done_q  <= frame_done_d;
      seq_err_q     <= seq_err_d;
      stall_q       <= stall_d;
      locked_q      <= locked_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

`ifdef SCAN_CAPTURE_DIFF_EN
  logic frame_diff;
  logic frame_changed_q, frame_changed_d;

  assign frame_changed_d = commit & frame_diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_changed_q <= 1'b0;
    end else begin
      frame_changed_q <= frame_changed_d;
    end
  end

  assign frame_changed = frame_changed_q;
`else
  assign frame_changed = 1'b0;
`endif

  scan_frame_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_col     (scan_cols),
    .wr_rows    (scan_rows),
    .commit     (commit),
    .rd_col     (rd_col),
`ifdef SCAN_CAPTURE_DIFF_EN
    .frame_diff (frame_diff),
`endif
    .rd_rows    (rd_rows)
  );

  assign frame_done  = frame_done_q;
  assign seq_err     = seq_err_q;
  assign stall       = stall_q;
  assign locked      = locked_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_dot_matrix_scan_capture.sv
// Scoreboard bench for dot_matrix_scan_capture: stimulus queues expected events,
// a negedge monitor pops and compares whenever the DUT signals one.
module tb_dot_matrix_scan_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_valid = 1'b0;
  logic [3:0]  scan_cols = '0;
  logic [15:0] scan_rows = '0;
  logic [3:0]  rd_col = '0;
  logic [15:0] rd_rows;
  logic        frame_done, frame_changed, seq_err, stall, locked;
  logic [7:0]  frame_count, err_count;

`ifdef SCAN_CAPTURE_DIFF_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic       chg;
    logic       is_stall;
  } ev_t;

  ev_t         fd_q[$];
  ev_t         er_q[$];
  logic [15:0] rd_q[$];
  logic        rd_strobe = 1'b0;
  logic        rd_pend = 1'b0;
  logic [15:0] ref_frame [16];

  dot_matrix_scan_capture dut (
    .clk          (clk),
    .rst          (rst),
    .scan_valid   (scan_valid),
    .scan_cols    (scan_cols),
    .scan_rows    (scan_rows),
    .rd_col       (rd_col),
    .rd_rows      (rd_rows),
    .frame_done   (frame_done),
    .frame_changed(frame_changed),
    .seq_err      (seq_err),
    .stall        (stall),
    .locked       (locked),
    .frame_count  (frame_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_strobe;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Pattern of column c in test frame f.
  function automatic logic [15:0] pat(input int f, input int c);
    logic [15:0] one;
    logic [15:0] cc;
    one = 16'h0001;
    cc  = 16'(c);
    case (f)
      0:       return one << c;
      1:       return 16'hA500 | cc;
      2:       return 16'h3C00 ^ cc;
      3:       return 16'h0F00 + cc;
      4:       return 16'h5A5A ^ (cc << 4);
      default: return ~(one << c);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int c, input logic [15:0] r);
    scan_valid = 1'b1;
    scan_cols  = 4'(c);
    scan_rows  = r;
    step();
    scan_valid = 1'b0;
  endtask

  task automatic send_range(input int f, input int first, input int last);
    for (int c = first; c <= last; c++) send(c, pat(f, c));
  endtask

  task automatic read_col(input int c);
    rd_col    = 4'(c);
    rd_strobe = 1'b1;
    rd_q.push_back(ref_frame[c]);
    step();
    rd_strobe = 1'b0;
  endtask

  task automatic push_fd(input logic [7:0] cnt, input logic chg);
    ev_t e;
    e.cyc = cyc + 1; e.cnt = cnt; e.chg = chg & DIFF; e.is_stall = 1'b0;
    fd_q.push_back(e);
  endtask

  task automatic push_err(input int at, input logic [7:0] cnt, input logic is_stall);
    ev_t e;
    e.cyc = at; e.cnt = cnt; e.chg = 1'b0; e.is_stall = is_stall;
    er_q.push_back(e);
  endtask

  task automatic load_ref(input int f);
    for (int c = 0; c < 16; c++) ref_frame[c] = pat(f, c);
  endtask

  // Monitor
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          chk("frame_done_unexpected", 1, 0);
        end else begin
          e = fd_q.pop_front();
          $display("frame_done: count=%0d changed=%0b cycle=%0d", frame_count, frame_changed, cyc);
          chk("fd_cycle", cyc, e.cyc);
          chk("fd_frame_count", {24'd0, frame_count}, {24'd0, e.cnt});
          chk("fd_frame_changed", {31'd0, frame_changed}, {31'd0, e.chg});
        end
      end else if (frame_changed) begin
        chk("frame_changed_without_done", 1, 0);
      end
      if (seq_err || stall) begin
        if (er_q.size() == 0) begin
          chk("error_event_unexpected", {30'd0, seq_err, stall}, 0);
        end else begin
          e = er_q.pop_front();
          $display("error event: seq_err=%0b stall=%0b err_count=%0d cycle=%0d", seq_err, stall, err_count, cyc);
          chk("err_kind", {30'd0, seq_err, stall}, e.is_stall ? 32'd1 : 32'd2);
          chk("err_cycle", cyc, e.cyc);
          chk("err_count", {24'd0, err_count}, {24'd0, e.cnt});
          if (stall) chk("stall_locked", {31'd0, locked}, 0);
        end
      end
      if (rd_pend) begin
        if (rd_q.size() == 0) begin
          chk("readback_unexpected", 1, 0);
        end else begin
          $display("readback: rd_rows=%04h", rd_rows);
          chk("readback", {16'd0, rd_rows}, {16'd0, rd_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 16; c++) ref_frame[c] = '0;

    // Reset state
    step(); step();
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_frame_count", {24'd0, frame_count}, 0);
    chk("rst_err_count", {24'd0, err_count}, 0);
    chk("rst_rd_rows", {16'd0, rd_rows}, 0);
    rst = 1'b0;
    step();

    // Clean frame A
    send(0, pat(0, 0));
    chk("locked_capture", {31'd0, locked}, 1);
    send_range(0, 1, 15);
    push_fd(8'd1, 1'b1);
    load_ref(0);
    step(); step();
    for (int c = 0; c < 16; c++) read_col(c);

    // Sequence error at col 5, then full frame B
    send_range(1, 0, 2);
    send(5, pat(1, 5));
    push_err(cyc, 8'd1, 1'b0);
    chk("locked_after_seq_err", {31'd0, locked}, 0);
    step();
    send_range(1, 0, 15);
    push_fd(8'd2, 1'b1);
    load_ref(1);
    step(); step();
    read_col(0); read_col(5); read_col(15);

    // Stall after col 7
    send_range(2, 0, 7);
    push_err(cyc + 1024, 8'd2, 1'b1);
    repeat (1030) step();
    chk("locked_after_stall", {31'd0, locked}, 0);
    read_col(3); read_col(7);

    // Duplicate col 3 with overwrite
    send_range(3, 0, 3);
    send(3, 16'hFFFF);
    send_range(3, 4, 15);
    push_fd(8'd3, 1'b1);
    load_ref(3);
    ref_frame[3] = 16'hFFFF;
    step(); step();
    read_col(3); read_col(2);

    // Back-to-back frames; read col 4 during the COMMIT cycle
    send_range(4, 0, 15);
    push_fd(8'd4, 1'b1);
    rd_col    = 4'd4;
    rd_strobe = 1'b1;
    rd_q.push_back(ref_frame[4]);
    send(0, pat(5, 0));
    rd_strobe = 1'b0;
    load_ref(4);
    send_range(5, 1, 15);
    push_fd(8'd5, 1'b1);
    load_ref(5);
    step(); step();
    read_col(4); read_col(9);

    // Identical frame repeated: no change reported
    send_range(5, 0, 15);
    push_fd(8'd6, 1'b0);
    step(); step();

    // Reset in the middle of a frame
    send_range(0, 0, 5);
    rst = 1'b1;
    #1;
    chk("midrst_locked", {31'd0, locked}, 0);
    chk("midrst_frame_count", {24'd0, frame_count}, 0);
    chk("midrst_err_count", {24'd0, err_count}, 0);
    chk("midrst_rd_rows", {16'd0, rd_rows}, 0);
    chk("midrst_pulses", {28'd0, frame_done, frame_changed, seq_err, stall}, 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 16; c++) ref_frame[c] = '0;
    read_col(0); read_col(9);
    step(); step();

    chk("fd_queue_drained", fd_q.size(), 0);
    chk("err_queue_drained", er_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
